// File: rtl/mac_accum_seq.sv
// mac_accum_seq
// Accumulates a programmable number of consecutive signed products from the
// multiply-add stage into a wider saturating accumulator. Each completed sum
// goes into a 2-entry output buffer that the consumer drains.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   cfg_len    terms per sum minus one, sampled on the first term of a group
//   in_valid   product valid this cycle (no back-pressure toward the multiplier)
//   in_p       signed product
//   out_valid  buffer head holds a completed sum
//   out_ready  consumer takes the head when high together with out_valid
//   out_sum    signed completed sum (possibly clamped)
//   out_sat    saturation happened somewhere in this sum's group
//   busy       a group is partially accumulated (state ACCUM)
//   err_ovf    sticky: a completed sum was dropped because the buffer was full
//
// Handshake: a transfer happens on a rising edge where out_valid and
// out_ready are both high; out_valid never depends on out_ready, and
// out_sum/out_sat stay stable while out_valid is high and out_ready low.
module mac_accum_seq #(
    parameter int P_WIDTH   = 44,
    parameter int ACC_WIDTH = 52,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CNT_WIDTH-1:0] cfg_len,
    input  logic                 in_valid,
    input  logic [P_WIDTH-1:0]   in_p,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic                 out_sat,
    output logic                 busy,
    output logic                 err_ovf
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t               r_state;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_len;
    logic                 r_sat;

    logic [ACC_WIDTH-1:0] r_head_sum;
    logic                 r_head_sat;
    logic [ACC_WIDTH-1:0] r_tail_sum;
    logic                 r_tail_sat;
    logic [1:0]           r_count;
    logic                 r_err_ovf;

    state_t               w_next_state;
    logic [ACC_WIDTH:0]   w_sum_wide;
    logic                 w_ovf;
    logic [ACC_WIDTH-1:0] w_sum_clamped;
    logic [ACC_WIDTH-1:0] w_acc_next;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic [CNT_WIDTH-1:0] w_len_next;
    logic                 w_sat_next;
    logic                 w_push;
    logic [ACC_WIDTH-1:0] w_push_sum;
    logic                 w_push_sat;
    logic                 w_pop;
    logic                 w_accept;

    // The accumulator is held at zero in IDLE, so one adder serves both the
    // first term of a group and every later term. One guard bit catches
    // signed overflow: the top two bits of the wide sum disagree.
    assign w_sum_wide = {r_acc[ACC_WIDTH-1], r_acc}
                      + {{(ACC_WIDTH+1-P_WIDTH){in_p[P_WIDTH-1]}}, in_p};
    assign w_ovf         = w_sum_wide[ACC_WIDTH] ^ w_sum_wide[ACC_WIDTH-1];
    assign w_sum_clamped = !w_ovf ? w_sum_wide[ACC_WIDTH-1:0]
                         : (w_sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX);

    always_comb begin
        w_next_state = r_state;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_len_next   = r_len;
        w_sat_next   = r_sat;
        w_push       = 1'b0;
        w_push_sum   = w_sum_clamped;
        w_push_sat   = r_sat | w_ovf;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (cfg_len == '0) begin
                        w_push = 1'b1;
                    end else begin
                        w_len_next   = cfg_len;
                        w_acc_next   = w_sum_clamped;
                        w_cnt_next   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        w_sat_next   = w_ovf;
                        w_next_state = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    if (r_cnt == r_len) begin
                        w_push       = 1'b1;
                        w_acc_next   = '0;
                        w_cnt_next   = '0;
                        w_sat_next   = 1'b0;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_acc_next = w_sum_clamped;
                        w_cnt_next = r_cnt + 1'b1;
                        w_sat_next = r_sat | w_ovf;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
            r_len   <= w_len_next;
            r_sat   <= w_sat_next;
        end
    end

    // Output buffer: head is the visible entry, tail the second slot.
    // A push into a full buffer is still accepted when the head pops in
    // the same cycle.
    assign w_pop    = (r_count != 2'd0) && out_ready;
    assign w_accept = w_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_sum <= '0;
            r_head_sat <= 1'b0;
            r_tail_sum <= '0;
            r_tail_sat <= 1'b0;
            r_count    <= 2'd0;
            r_err_ovf  <= 1'b0;
        end else begin
            if (w_push && !w_accept) begin
                r_err_ovf <= 1'b1;
            end
            if (w_pop) begin
                if (r_count == 2'd2) begin
                    r_head_sum <= r_tail_sum;
                    r_head_sat <= r_tail_sat;
                    if (w_accept) begin
                        r_tail_sum <= w_push_sum;
                        r_tail_sat <= w_push_sat;
                    end
                end else if (w_accept) begin
                    r_head_sum <= w_push_sum;
                    r_head_sat <= w_push_sat;
                end
            end else if (w_accept) begin
                if (r_count == 2'd0) begin
                    r_head_sum <= w_push_sum;
                    r_head_sat <= w_push_sat;
                end else begin
                    r_tail_sum <= w_push_sum;
                    r_tail_sat <= w_push_sat;
                end
            end
            r_count <= r_count + {1'b0, w_accept} - {1'b0, w_pop};
        end
    end

    assign out_valid = (r_count != 2'd0);
    assign out_sum   = r_head_sum;
    assign out_sat   = r_head_sat;
    assign busy      = (r_state == ST_ACCUM);
    assign err_ovf   = r_err_ovf;

endmodule

// File: tb/tb_mac_accum_seq.sv
// Directed bench for mac_accum_seq, built with a 45-bit accumulator so that
// saturation is reachable with 44-bit products.
module tb_mac_accum_seq;

    localparam int PW = 44;
    localparam int AW = 45;
    localparam int CW = 8;

    localparam logic signed [PW-1:0] P_MAX = {1'b0, {(PW-1){1'b1}}};
    localparam logic signed [PW-1:0] P_MIN = {1'b1, {(PW-1){1'b0}}};
    localparam logic signed [AW-1:0] A_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] A_MIN = {1'b1, {(AW-1){1'b0}}};

    logic          clk;
    logic          rst;
    logic [CW-1:0] cfg_len;
    logic          in_valid;
    logic [PW-1:0] in_p;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic          out_sat;
    logic          busy;
    logic          err_ovf;

    int total;
    int bad;

    mac_accum_seq #(.P_WIDTH(PW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .cfg_len(cfg_len), .in_valid(in_valid),
        .in_p(in_p), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_sat(out_sat), .busy(busy), .err_ovf(err_ovf)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are read at
    // the same point, well away from the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic term(input logic signed [PW-1:0] p);
        in_valid = 1'b1;
        in_p     = p;
        step();
        in_valid = 1'b0;
        in_p     = '0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        cfg_len = 8'd0; out_ready = 1'b0;
        rst = 1'b1; in_valid = 1'b1; in_p = 44'd7;
        step(); step();
        rst = 1'b0; in_valid = 1'b0; in_p = '0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (out_sum !== '0) begin bad++; $display("FAIL reset_sum got=%0d exp=0", $signed(out_sum)); end
        total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b exp=0", out_sat); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (err_ovf !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_ovf); end
        idle();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_ignores_in got=%b exp=0", out_valid); end
    endtask

    task automatic test_basic();
        logic signed [PW-1:0] t[4];
        t = '{44'sd5, -44'sd2, 44'sd10, 44'sd7};
        out_ready = 1'b1; cfg_len = 8'd3;
        for (int i = 0; i < 3; i++) begin
            term(t[i]);
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy%0d got=%b exp=1", i, busy); end
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early%0d got=%b exp=0", i, out_valid); end
        end
        term(t[3]);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        total++; if ($signed(out_sum) !== 45'sd20) begin bad++; $display("FAIL basic_sum got=%0d exp=20", $signed(out_sum)); end
        total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL basic_sat got=%b exp=0", out_sat); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
        idle();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_len0_gaps();
        out_ready = 1'b1; cfg_len = 8'd0;
        term(-44'sd1);
        total++; if (out_valid !== 1'b1 || $signed(out_sum) !== -45'sd1) begin bad++; $display("FAIL len0_a got=%b/%0d exp=1/-1", out_valid, $signed(out_sum)); end
        term(44'sd3);
        total++; if (out_valid !== 1'b1 || $signed(out_sum) !== 45'sd3) begin bad++; $display("FAIL len0_b got=%b/%0d exp=1/3", out_valid, $signed(out_sum)); end
        cfg_len = 8'd1;
        term(44'sd4);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL gap_drain got=%b exp=0", out_valid); end
        idle(); idle();
        total++; if (busy !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL gap_hold got=%b/%b exp=1/0", busy, out_valid); end
        term(44'sd6);
        total++; if (out_valid !== 1'b1 || $signed(out_sum) !== 45'sd10) begin bad++; $display("FAIL gap_sum got=%b/%0d exp=1/10", out_valid, $signed(out_sum)); end
        idle();
    endtask

    task automatic test_saturation();
        out_ready = 1'b1; cfg_len = 8'd2;
        term(P_MAX); term(P_MAX); term(P_MAX);
        total++; if (out_sum !== A_MAX || out_sat !== 1'b1) begin bad++; $display("FAIL sat_pos got=%0d/%b exp=%0d/1", $signed(out_sum), out_sat, A_MAX); end
        idle();
        term(P_MIN); term(P_MIN); term(P_MIN);
        total++; if (out_sum !== A_MIN || out_sat !== 1'b1) begin bad++; $display("FAIL sat_neg got=%0d/%b exp=%0d/1", $signed(out_sum), out_sat, A_MIN); end
        idle();
        cfg_len = 8'd3;
        term(P_MAX); term(P_MAX); term(P_MAX); term(-44'sd5);
        total++; if (out_sum !== A_MAX - 45'sd5 || out_sat !== 1'b1) begin bad++; $display("FAIL sat_continue got=%0d/%b exp=%0d/1", $signed(out_sum), out_sat, A_MAX - 45'sd5); end
        idle();
        cfg_len = 8'd1;
        term(44'sd1); term(44'sd1);
        total++; if ($signed(out_sum) !== 45'sd2 || out_sat !== 1'b0) begin bad++; $display("FAIL sat_clear got=%0d/%b exp=2/0", $signed(out_sum), out_sat); end
        idle();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; cfg_len = 8'd1;
        term(44'sd1); term(44'sd2);
        total++; if (out_valid !== 1'b1 || $signed(out_sum) !== 45'sd3) begin bad++; $display("FAIL b2b_first got=%b/%0d exp=1/3", out_valid, $signed(out_sum)); end
        term(44'sd3);
        total++; if (busy !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL b2b_mid got=%b/%b exp=1/0", busy, out_valid); end
        term(44'sd4);
        total++; if (out_valid !== 1'b1 || $signed(out_sum) !== 45'sd7) begin bad++; $display("FAIL b2b_second got=%b/%0d exp=1/7", out_valid, $signed(out_sum)); end
        idle();
    endtask

    task automatic test_full_pop();
        do_reset();
        out_ready = 1'b0; cfg_len = 8'd0;
        term(44'sd1); term(44'sd2);
        out_ready = 1'b1;
        term(44'sd3);
        total++; if (out_valid !== 1'b1 || $signed(out_sum) !== 45'sd2) begin bad++; $display("FAIL fullpop_2 got=%b/%0d exp=1/2", out_valid, $signed(out_sum)); end
        total++; if (err_ovf !== 1'b0) begin bad++; $display("FAIL fullpop_err got=%b exp=0", err_ovf); end
        idle();
        total++; if (out_valid !== 1'b1 || $signed(out_sum) !== 45'sd3) begin bad++; $display("FAIL fullpop_3 got=%b/%0d exp=1/3", out_valid, $signed(out_sum)); end
        idle();
        total++; if (out_valid !== 1'b0 || err_ovf !== 1'b0) begin bad++; $display("FAIL fullpop_end got=%b/%b exp=0/0", out_valid, err_ovf); end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0; cfg_len = 8'd0;
        term(44'sd1); term(44'sd2);
        total++; if (err_ovf !== 1'b0) begin bad++; $display("FAIL bp_err_early got=%b exp=0", err_ovf); end
        term(44'sd3);
        total++; if (err_ovf !== 1'b1) begin bad++; $display("FAIL bp_err got=%b exp=1", err_ovf); end
        idle();
        total++; if (out_valid !== 1'b1 || $signed(out_sum) !== 45'sd1) begin bad++; $display("FAIL bp_hold got=%b/%0d exp=1/1", out_valid, $signed(out_sum)); end
        out_ready = 1'b1;
        idle();
        total++; if (out_valid !== 1'b1 || $signed(out_sum) !== 45'sd2) begin bad++; $display("FAIL bp_second got=%b/%0d exp=1/2", out_valid, $signed(out_sum)); end
        idle();
        total++; if (out_valid !== 1'b0 || err_ovf !== 1'b1) begin bad++; $display("FAIL bp_end got=%b/%b exp=0/1", out_valid, err_ovf); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; cfg_len = 8'd0;
        term(44'sd7);
        cfg_len = 8'd4;
        term(44'sd9); term(44'sd9);
        total++; if (busy !== 1'b1 || out_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre got=%b/%b exp=1/1", busy, out_valid); end
        do_reset();
        total++; if (out_valid !== 1'b0 || out_sum !== '0 || out_sat !== 1'b0 || busy !== 1'b0 || err_ovf !== 1'b0) begin
            bad++; $display("FAIL rmid_zero got=%b/%0d/%b/%b/%b exp=0/0/0/0/0", out_valid, $signed(out_sum), out_sat, busy, err_ovf);
        end
        out_ready = 1'b1; cfg_len = 8'd4;
        term(44'sd1);
        cfg_len = 8'd0;
        for (int i = 0; i < 3; i++) term(44'sd1);
        total++; if (busy !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL rmid_len_held got=%b/%b exp=1/0", busy, out_valid); end
        term(44'sd1);
        total++; if (out_valid !== 1'b1 || $signed(out_sum) !== 45'sd5 || out_sat !== 1'b0) begin
            bad++; $display("FAIL rmid_sum got=%b/%0d/%b exp=1/5/0", out_valid, $signed(out_sum), out_sat);
        end
        idle();
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; cfg_len = '0; in_valid = 1'b0; in_p = '0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_len0_gaps();
        test_saturation();
        test_back_to_back();
        test_full_pop();
        test_back_pressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
